// File: rtl/bidir_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bidir_bridge_pkg
// Brief   : Shared direction/state types and counter sizing for bidir_bridge.
// Revision: 1.0  initial release
// ============================================================================
package bidir_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    A2C  = 2'd1,
    TURN = 2'd2,
    C2A  = 2'd3
  } dir_state_e;

  typedef enum logic {
    DIR_A = 1'b0,
    DIR_C = 1'b1
  } dir_e;

  // One counter serves both the hold limit and the turnaround gap.
  function automatic int cnt_width(input int turn_cyc, input int max_hold);
    int m;
    m = (turn_cyc > max_hold) ? turn_cyc : max_hold;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(1, 16);

endpackage
`default_nettype wire

// File: rtl/bidir_bridge_ch.sv
`default_nettype none
// ============================================================================
// Module  : bidir_bridge_ch
// Brief   : One bridge channel: direction FSM, hold/turn counter, data path.
//           Define BIDIR_BRIDGE_KEEPER_EN to hold last data while oe is low.
// Revision: 1.0  initial release
// ============================================================================
module bidir_bridge_ch
  import bidir_bridge_pkg::*;
#(
  parameter int W        = 8,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] c_in,
  input  logic         a_req,
  input  logic         c_req,
  output logic [W-1:0] a_out,
  output logic [W-1:0] c_out,
  output logic         a_oe,
  output logic         c_oe,
  output logic         a_gnt,
  output logic         c_gnt,
  output logic         busy
);

  localparam int                c_cnt_w     = cnt_width(TURN_CYC, MAX_HOLD);
  localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(MAX_HOLD - 1);
  localparam logic [c_cnt_w-1:0] c_turn_last = c_cnt_w'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
  localparam dir_state_e        c_exit_state = (TURN_CYC == 0) ? IDLE : TURN;

  dir_state_e         r_state;
  dir_e               r_last_dir;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_a_gnt;
  logic               r_c_gnt;
  logic               r_a_oe;
  logic               r_c_oe;
  logic [W-1:0]       r_a_data;
  logic [W-1:0]       r_c_data;

  logic w_pick_a;
  logic w_pick_c;

  // Ties go to the side that did not own the bus last.
  assign w_pick_a = a_req && (!c_req || (r_last_dir == DIR_C));
  assign w_pick_c = c_req && (!a_req || (r_last_dir == DIR_A));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last_dir <= DIR_C;
      r_cnt      <= '0;
      r_a_gnt    <= 1'b0;
      r_c_gnt    <= 1'b0;
      r_a_oe     <= 1'b0;
      r_c_oe     <= 1'b0;
      r_a_data   <= '0;
      r_c_data   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_a) begin
            r_state    <= A2C;
            r_last_dir <= DIR_A;
            r_cnt      <= '0;
            r_a_gnt    <= 1'b1;
            r_c_oe     <= 1'b1;
            r_c_data   <= a_in;
          end else if (w_pick_c) begin
            r_state    <= C2A;
            r_last_dir <= DIR_C;
            r_cnt      <= '0;
            r_c_gnt    <= 1'b1;
            r_a_oe     <= 1'b1;
            r_a_data   <= c_in;
          end
        end
        A2C: begin
          // Opposite request pending for MAX_HOLD cycles forces a turnaround.
          if (!a_req || (c_req && (r_cnt == c_hold_last))) begin
            r_state <= c_exit_state;
            r_cnt   <= '0;
            r_a_gnt <= 1'b0;
            r_c_oe  <= 1'b0;
          end else begin
            r_c_data <= a_in;
            if (c_req) r_cnt <= r_cnt + 1'b1;
          end
        end
        C2A: begin
          if (!c_req || (a_req && (r_cnt == c_hold_last))) begin
            r_state <= c_exit_state;
            r_cnt   <= '0;
            r_c_gnt <= 1'b0;
            r_a_oe  <= 1'b0;
          end else begin
            r_a_data <= c_in;
            if (a_req) r_cnt <= r_cnt + 1'b1;
          end
        end
        TURN: begin
          if (r_cnt == c_turn_last) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_a_gnt <= 1'b0;
          r_c_gnt <= 1'b0;
          r_a_oe  <= 1'b0;
          r_c_oe  <= 1'b0;
        end
      endcase
    end
  end

  assign a_gnt = r_a_gnt;
  assign c_gnt = r_c_gnt;
  assign a_oe  = r_a_oe;
  assign c_oe  = r_c_oe;
  assign busy  = (r_state != IDLE);

`ifdef BIDIR_BRIDGE_KEEPER_EN
  assign a_out = r_a_data;
  assign c_out = r_c_data;
`else
  assign a_out = r_a_oe ? r_a_data : '0;
  assign c_out = r_c_oe ? r_c_data : '0;
`endif

endmodule
`default_nettype wire

// File: rtl/bidir_bridge.sv
`default_nettype none
// ============================================================================
// Module  : bidir_bridge
// Brief   : NCH independent A<->C bridge channels with split tri-state pads.
//           Define BIDIR_BRIDGE_KEEPER_EN to hold last data while oe is low.
// Revision: 1.0  initial release
// ============================================================================
module bidir_bridge
  import bidir_bridge_pkg::*;
#(
  parameter int W        = 8,
  parameter int NCH      = 2,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*W-1:0] a_in,
  output logic [NCH*W-1:0] a_out,
  output logic [NCH-1:0]   a_oe,
  input  logic [NCH*W-1:0] c_in,
  output logic [NCH*W-1:0] c_out,
  output logic [NCH-1:0]   c_oe,
  input  logic [NCH-1:0]   a_req,
  input  logic [NCH-1:0]   c_req,
  output logic [NCH-1:0]   a_gnt,
  output logic [NCH-1:0]   c_gnt,
  output logic [NCH-1:0]   busy
);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    bidir_bridge_ch #(
      .W        (W),
      .TURN_CYC (TURN_CYC),
      .MAX_HOLD (MAX_HOLD)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .a_in  (a_in[k*W +: W]),
      .c_in  (c_in[k*W +: W]),
      .a_req (a_req[k]),
      .c_req (c_req[k]),
      .a_out (a_out[k*W +: W]),
      .c_out (c_out[k*W +: W]),
      .a_oe  (a_oe[k]),
      .c_oe  (c_oe[k]),
      .a_gnt (a_gnt[k]),
      .c_gnt (c_gnt[k]),
      .busy  (busy[k])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_bidir_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_bidir_bridge
// Brief   : Directed self-checking bench for bidir_bridge, channel-0 data
//           scoreboard. Honours BIDIR_BRIDGE_KEEPER_EN for keeper expectations.
// Revision: 1.0  initial release
// ============================================================================
module tb_bidir_bridge;

  localparam int W        = 8;
  localparam int NCH      = 2;
  localparam int TURN_CYC = 1;
  localparam int MAX_HOLD = 4;
`ifdef BIDIR_BRIDGE_KEEPER_EN
  localparam bit KEEP = 1'b1;
`else
  localparam bit KEEP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NCH*W-1:0] a_in, c_in, a_out, c_out;
  logic [NCH-1:0]   a_oe, c_oe, a_req, c_req, a_gnt, c_gnt, busy;

  logic [7:0] sb_c[$];
  logic [7:0] sb_a[$];
  int checks   = 0;
  int failures = 0;
  bit ch1_idle = 1'b1;

  bidir_bridge #(
    .W(W), .NCH(NCH), .TURN_CYC(TURN_CYC), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_out(a_out), .a_oe(a_oe),
    .c_in(c_in), .c_out(c_out), .c_oe(c_oe),
    .a_req(a_req), .c_req(c_req),
    .a_gnt(a_gnt), .c_gnt(c_gnt), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then check exclusivity and retire scoreboard entries.
  task automatic step();
    logic [7:0] e;
    @(posedge clk);
    #1;
    chk("oe_exclusive", 32'(a_oe & c_oe), 32'd0);
    if (c_oe[0]) begin
      chk("sb_c_nonempty", 32'(sb_c.size() > 0), 32'd1);
      if (sb_c.size() > 0) begin
        e = sb_c.pop_front();
        chk("c_out_data", 32'(c_out[7:0]), 32'(e));
      end
    end
    if (a_oe[0]) begin
      chk("sb_a_nonempty", 32'(sb_a.size() > 0), 32'd1);
      if (sb_a.size() > 0) begin
        e = sb_a.pop_front();
        chk("a_out_data", 32'(a_out[7:0]), 32'(e));
      end
    end
    if (ch1_idle)
      chk("ch1_idle", 32'({busy[1], a_oe[1], c_oe[1], a_gnt[1], c_gnt[1], a_out[15:8], c_out[15:8]}), 32'd0);
  endtask

  initial begin
    a_req = '0; c_req = '0; a_in = '0; c_in = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oe",   32'({a_oe, c_oe}),   32'd0);
    chk("rst_gnt",  32'({a_gnt, c_gnt}), 32'd0);
    chk("rst_busy", 32'(busy),           32'd0);
    chk("rst_data", {a_out, c_out},      32'd0);
    rst = 1'b0;
    step(); step();
    chk("idle_busy", 32'(busy), 32'd0);

    // single A->C transfer
    a_req = 2'b01; a_in[7:0] = 8'hA5; sb_c.push_back(8'hA5);
    step();
    chk("t1_a_gnt", 32'(a_gnt), 32'd1);
    chk("t1_c_oe",  32'(c_oe),  32'd1);
    chk("t1_a_oe",  32'(a_oe),  32'd0);
    chk("t1_busy",  32'(busy),  32'd1);
    for (int i = 1; i < 5; i++) begin
      a_in[7:0] = 8'(17 * i);
      sb_c.push_back(a_in[7:0]);
      step();
    end
    a_req = 2'b00; a_in[7:0] = 8'hEE;
    step();
    chk("t6_turn_busy", 32'(busy),  32'd1);
    chk("t6_turn_oe",   32'({a_oe, c_oe}), 32'd0);
    chk("t6_turn_gnt",  32'({a_gnt, c_gnt}), 32'd0);
    chk("t6_c_out",     32'(c_out[7:0]), KEEP ? 32'h44 : 32'h00);
    step();
    chk("t7_idle", 32'(busy), 32'd0);

    // tie-break after reset: A first, then C
    rst = 1'b1; step(); rst = 1'b0;
    a_req = 2'b01; c_req = 2'b01; a_in[7:0] = 8'h5A; c_in[7:0] = 8'hC3;
    sb_c.push_back(8'h5A);
    step();
    chk("tie_a_gnt", 32'(a_gnt), 32'd1);
    chk("tie_c_gnt", 32'(c_gnt), 32'd0);
    a_req = 2'b00;
    step();
    chk("tie_turn_busy", 32'(busy), 32'd1);
    chk("tie_turn_oe",   32'({a_oe, c_oe}), 32'd0);
    a_req = 2'b01;
    step();
    chk("tie_idle", 32'(busy), 32'd0);
    sb_a.push_back(8'hC3);
    step();
    chk("tie2_c_gnt", 32'(c_gnt), 32'd1);
    chk("tie2_a_gnt", 32'(a_gnt), 32'd0);
    chk("tie2_a_oe",  32'(a_oe),  32'd1);
    a_req = 2'b00; c_req = 2'b00;
    step(); step();
    chk("tie_done", 32'(busy), 32'd0);

    // forced turnaround A->C then C->A with MAX_HOLD=4
    a_req = 2'b01; a_in[7:0] = 8'h10; sb_c.push_back(8'h10); step();
    a_in[7:0] = 8'h11; sb_c.push_back(8'h11); step();
    c_req = 2'b01; c_in[7:0] = 8'h77;
    a_in[7:0] = 8'h12; sb_c.push_back(8'h12); step();
    a_in[7:0] = 8'h13; sb_c.push_back(8'h13); step();
    a_in[7:0] = 8'h14; sb_c.push_back(8'h14); step();
    chk("hold_still_a2c", 32'(a_gnt), 32'd1);
    a_in[7:0] = 8'h15;
    step();
    chk("forced_turn_busy", 32'(busy), 32'd1);
    chk("forced_turn_oe",   32'({a_oe, c_oe}), 32'd0);
    chk("forced_turn_gnt",  32'({a_gnt, c_gnt}), 32'd0);
    step();
    chk("forced_idle", 32'(busy), 32'd0);
    c_in[7:0] = 8'h78; sb_a.push_back(8'h78); step();
    chk("forced_c_gnt", 32'(c_gnt), 32'd1);
    chk("forced_a_oe",  32'(a_oe),  32'd1);
    c_in[7:0] = 8'h79; sb_a.push_back(8'h79); step();
    c_in[7:0] = 8'h7A; sb_a.push_back(8'h7A); step();
    c_in[7:0] = 8'h7B; sb_a.push_back(8'h7B); step();
    chk("hold_still_c2a", 32'(c_gnt), 32'd1);
    c_in[7:0] = 8'h7C;
    step();
    chk("forced2_gnt",  32'({a_gnt, c_gnt}), 32'd0);
    chk("forced2_busy", 32'(busy), 32'd1);
    a_req = 2'b00; c_req = 2'b00;
    step();
    chk("forced2_idle", 32'(busy), 32'd0);

    // asynchronous reset inside A2C
    a_req = 2'b01; a_in[7:0] = 8'h3C; sb_c.push_back(8'h3C);
    step();
    chk("pre_async_c_oe", 32'(c_oe), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_c_oe",  32'(c_oe),  32'd0);
    chk("async_a_gnt", 32'(a_gnt), 32'd0);
    chk("async_busy",  32'(busy),  32'd0);
    a_req = 2'b00;
    step();
    rst = 1'b0;
    step();
    chk("post_async_idle", 32'(busy), 32'd0);

    // keeper behaviour on channel 0
    a_req = 2'b01; a_in[7:0] = 8'h3C; sb_c.push_back(8'h3C);
    step();
    chk("keep_a_gnt", 32'(a_gnt), 32'd1);
    a_req = 2'b00; a_in[7:0] = 8'h00;
    step();
    chk("keep_turn_c_oe", 32'(c_oe), 32'd0);
    chk("keep_turn_c_out", 32'(c_out[7:0]), KEEP ? 32'h3C : 32'h00);
    step();
    chk("keep_idle_c_out", 32'(c_out[7:0]), KEEP ? 32'h3C : 32'h00);

    // channel 1 on its own, channel 0 stays idle
    ch1_idle = 1'b0;
    c_req = 2'b10; c_in[15:8] = 8'h9E;
    step();
    chk("ch1_c_gnt", 32'(c_gnt), 32'h2);
    chk("ch1_a_oe",  32'(a_oe),  32'h2);
    chk("ch1_busy",  32'(busy),  32'h2);
    chk("ch1_a_out", 32'(a_out[15:8]), 32'h9E);
    c_req = 2'b00;
    step();
    chk("ch1_turn_busy", 32'(busy), 32'h2);
    chk("ch1_turn_a_out", 32'(a_out[15:8]), KEEP ? 32'h9E : 32'h00);
    step();
    chk("ch1_idle_end", 32'(busy), 32'd0);

    chk("sb_c_drained", 32'(sb_c.size()), 32'd0);
    chk("sb_a_drained", 32'(sb_a.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
